// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, the IF/ID register, the
// Stop-driven halt FSM and a saturating count of instructions handed to decode.
module if_stage #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    IMM8_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] im_addr_o,
   input  logic [DATA_WIDTH-1:0] im_rdata_i,
   input  logic                  stall_IF_i,
   input  logic                  flush_IF_ID_i,
   input  logic                  Jump_i,
   input  logic [IMM8_WIDTH-1:0] jumpAddr_i,
   input  logic                  Stop_i,
   input  logic                  branch_taken_i,
   input  logic [ADDR_WIDTH-1:0] branch_target_i,
   output logic [ADDR_WIDTH-1:0] PCD_o,
   output logic [DATA_WIDTH-1:0] instr_D_o,
   output logic                  valid_D_o,
   output logic                  halted_o,
   output logic [15:0]           fetch_cnt_o
);

   typedef enum logic {RUN, HALT} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pcf;
   logic [ADDR_WIDTH-1:0] jump_pc;
   logic                  jmp, stp;
   logic                  in_halt;

   assign im_addr_o = pcf;
   assign in_halt   = (state == HALT);
   assign halted_o  = in_halt;

   // Decode events only count when a real, non-stalled instruction presents them.
   assign jmp = valid_D_o & ~stall_IF_i & Jump_i;
   assign stp = valid_D_o & ~stall_IF_i & Stop_i;

   generate
      if (IMM8_WIDTH >= ADDR_WIDTH) begin : g_jtrunc
         assign jump_pc = jumpAddr_i[ADDR_WIDTH-1:0];
      end else begin : g_jzext
         assign jump_pc = {{(ADDR_WIDTH-IMM8_WIDTH){1'b0}}, jumpAddr_i};
      end
   endgenerate

   // Halt FSM and fetch PC; a taken branch is older than any Stop and squashes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         pcf   <= '0;
      end else begin
         if (branch_taken_i)
            state <= RUN;
         else if (stp)
            state <= HALT;

         if (branch_taken_i)
            pcf <= branch_target_i;
         else if (in_halt || stp || stall_IF_i)
            pcf <= pcf;
         else if (jmp)
            pcf <= jump_pc;
         else
            pcf <= pcf + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PCD_o       <= '0;
         instr_D_o   <= NOP_INSTR;
         valid_D_o   <= 1'b0;
         fetch_cnt_o <= '0;
      end else if (branch_taken_i || flush_IF_ID_i) begin
         PCD_o     <= '0;
         instr_D_o <= NOP_INSTR;
         valid_D_o <= 1'b0;
      end else if (stall_IF_i) begin
         PCD_o     <= PCD_o;
         instr_D_o <= instr_D_o;
         valid_D_o <= valid_D_o;
      end else if (jmp || stp || in_halt) begin
         PCD_o     <= '0;
         instr_D_o <= NOP_INSTR;
         valid_D_o <= 1'b0;
      end else begin
         PCD_o     <= pcf;
         instr_D_o <= im_rdata_i;
         valid_D_o <= 1'b1;
         if (fetch_cnt_o != 16'hFFFF)
            fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end
   end

endmodule
